float_to_int_iter: RTL and testbench
====================================

FLOAT_TO_INT_ITER -- requirements
Module: float_to_int_iter

Interface
REQ-001 SHALL have parameter: SHIFT_PER_CYCLE, 8, maximum mantissa bit positions shifted per SHIFT cycle (legal 1..16).
REQ-002 SHALL have port: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: io_in_valid  input  1  io_in_bits holds an operand.
REQ-005 SHALL have port: io_in_ready  output  1  block can accept an operand (high only in IDLE).
REQ-006 SHALL have port: io_in_bits  input  64  IEEE-754 binary64 operand (same bit format as $realtobits).
REQ-007 SHALL have port: io_out_valid  output  1  result registers valid.
REQ-008 SHALL have port: io_out_ready  input  1  consumer accepts result.
REQ-009 SHALL have port: io_out_bits  output  64  signed two's-complement integer result.
REQ-010 SHALL have port: io_out_overflow  output  1  result saturated (|x| >= 2^63, or infinity).
REQ-011 SHALL have port: io_out_invalid  output  1  operand was NaN.

Function
REQ-012 SHALL convert with truncation toward zero, matching $rtoi for every in-range operand.
REQ-013 SHALL fire input on io_in_valid && io_in_ready; operand captured that edge.
REQ-014 SHALL implement FSM states IDLE, SHIFT, NEG, DONE; IDLE -> SHIFT on accept if shift amount > 0 and operand not special, else IDLE -> NEG.
REQ-015 SHALL decode: s = bit63, e = bits62:52, f = bits51:0, E = e - 1023, mantissa m = {1,f} zero-extended to 64 bits.
REQ-016 SHALL treat e == 0 (zero or subnormal) and E < 0 as magnitude 0, no flags.
REQ-017 SHALL treat e == 2047 with f != 0 as NaN: result 0, io_out_invalid = 1.
REQ-018 SHALL treat e == 2047 with f == 0 (infinity), or E >= 63, as overflow: result 0x7FFFFFFFFFFFFFFF (s=0) or 0x8000000000000000 (s=1), io_out_overflow = 1.
REQ-019 SHALL, as sole exception to REQ-018, output exactly 0x8000000000000000 with no flags for operand 0xC3E0000000000000 (-2^63).
REQ-020 SHALL shift m right by 52-E when 0 <= E < 52, and left by E-52 when 52 <= E <= 62.
REQ-021 SHALL, in SHIFT, shift by min(remaining, SHIFT_PER_CYCLE) per cycle, decrementing remaining; go to NEG when remaining reaches 0.
REQ-022 SHALL, in NEG, replace the magnitude with its two's complement when s = 1 (non-special cases only), load io_out_bits and flags, then go to DONE.
REQ-023 SHALL assert io_out_valid only in DONE; DONE -> IDLE on io_out_ready; io_out_bits and flags SHALL hold stable while io_out_valid && !io_out_ready.
REQ-024 SHALL give latency from accept edge to io_out_valid high of 2 + ceil(shift/SHIFT_PER_CYCLE) cycles (2 for specials and zero shift).
REQ-025 SHALL not accept a new operand in the cycle the result is consumed; earliest next accept is the following cycle.
REQ-026 SHALL deassert io_in_ready in SHIFT, NEG and DONE; io_in_valid there SHALL be ignored.

Reset
REQ-027 SHALL, on reset high at any clock edge, including mid-SHIFT or in DONE, enter IDLE and discard any operation in flight.
REQ-028 SHALL reset io_out_valid = 0, io_out_bits = 0, io_out_overflow = 0, io_out_invalid = 0; io_in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-029 SHALL cover 0x4059000000000000 (100.0) -> 0x0000000000000064, no flags, out_valid 8 cycles after accept (shift 46).
REQ-030 SHALL cover 0xC00C000000000000 (-3.5) -> 0xFFFFFFFFFFFFFFFD, no flags, latency 9; and 0x3FE0000000000000 (0.5) -> 0, latency 2.
REQ-031 SHALL cover 0x43E0000000000000 -> 0x7FFFFFFFFFFFFFFF with overflow=1; 0xC3E0000000000000 -> 0x8000000000000000, flags 0; 0xFFF0000000000000 -> 0x8000000000000000 with overflow=1.
REQ-032 SHALL cover 0x7FF8000000000000 (NaN) -> 0, invalid=1, overflow=0, latency 2.
REQ-033 SHALL cover 0x43C0000000000001 (2^61 + 2^9) -> 0x2000000000000200 via left shift 9; hold io_out_ready low 5 cycles -> outputs stable, io_in_ready low throughout.
REQ-034 SHALL cover reset asserted on the 3rd SHIFT cycle of the 100.0 case -> next cycle IDLE, io_out_valid 0, io_in_ready 1, no spurious result.

Source files
------------

// File: rtl/float_to_int_iter.sv
// Iterative binary64 -> int64 converter, truncating toward zero.
// Mantissa alignment runs a bounded number of bit positions per cycle.
module float_to_int_iter #(
    parameter int SHIFT_PER_CYCLE = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [63:0] io_in_bits,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [63:0] io_out_bits,
    output logic        io_out_overflow,
    output logic        io_out_invalid
);

    typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;

    localparam logic [5:0]  STEP    = 6'(SHIFT_PER_CYCLE);
    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    state_t      state;
    logic [63:0] mag;
    logic [5:0]  rem;
    logic        left;
    logic        neg;
    logic        ovf;
    logic        inv;

    logic        sgn;
    logic [10:0] ex;
    logic [51:0] fr;
    logic [63:0] mant;
    logic [10:0] rdiff;
    logic [10:0] ldiff;
    logic [5:0]  amt_in;
    logic [5:0]  step;
    logic        is_nan;
    logic        is_inf;
    logic        is_min;
    logic        is_big;
    logic        is_small;
    logic        is_right;

    assign sgn      = io_in_bits[63];
    assign ex       = io_in_bits[62:52];
    assign fr       = io_in_bits[51:0];
    assign mant     = {11'b0, 1'b1, fr};
    assign is_nan   = (ex == 11'h7FF) && (fr != 52'd0);
    assign is_inf   = (ex == 11'h7FF) && (fr == 52'd0);
    assign is_min   = (io_in_bits == 64'hC3E0_0000_0000_0000);
    assign is_big   = (ex >= 11'd1086);
    assign is_small = (ex < 11'd1023);
    assign is_right = (ex < 11'd1075);
    assign rdiff    = 11'd1075 - ex;
    assign ldiff    = ex - 11'd1075;
    assign amt_in   = is_right ? rdiff[5:0] : ldiff[5:0];

    always_comb begin
        step = STEP;
        if (rem < STEP)
            step = rem;
    end

    assign io_in_ready  = (state == IDLE);
    assign io_out_valid = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            mag             <= 64'd0;
            rem             <= 6'd0;
            left            <= 1'b0;
            neg             <= 1'b0;
            ovf             <= 1'b0;
            inv             <= 1'b0;
            io_out_bits     <= 64'd0;
            io_out_overflow <= 1'b0;
            io_out_invalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        neg   <= sgn;
                        ovf   <= 1'b0;
                        inv   <= 1'b0;
                        left  <= !is_right;
                        rem   <= amt_in;
                        mag   <= mant;
                        state <= NEG;
                        // Specials bypass SHIFT with a preloaded, already-signed magnitude
                        if (is_nan) begin
                            mag <= 64'd0;
                            inv <= 1'b1;
                            rem <= 6'd0;
                        end else if (is_min) begin
                            mag <= INT_MIN;
                            neg <= 1'b0;
                            rem <= 6'd0;
                        end else if (is_inf || is_big) begin
                            mag <= sgn ? INT_MIN : INT_MAX;
                            neg <= 1'b0;
                            ovf <= 1'b1;
                            rem <= 6'd0;
                        end else if (is_small) begin
                            mag <= 64'd0;
                            rem <= 6'd0;
                        end else if (amt_in != 6'd0) begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mag <= left ? (mag << step) : (mag >> step);
                    rem <= rem - step;
                    if (rem == step)
                        state <= NEG;
                end
                NEG: begin
                    io_out_bits     <= neg ? (64'd0 - mag) : mag;
                    io_out_overflow <= ovf;
                    io_out_invalid  <= inv;
                    state           <= DONE;
                end
                DONE: begin
                    if (io_out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int_iter.sv
// Directed bench for float_to_int_iter: values, flags, latency,
// output hold under backpressure and mid-operation reset.
module tb_float_to_int_iter;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [63:0] io_in_bits;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [63:0] io_out_bits;
    logic        io_out_overflow;
    logic        io_out_invalid;

    int vecs  = 0;
    int fails = 0;

    float_to_int_iter #(.SHIFT_PER_CYCLE(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_bits      (io_in_bits),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_bits     (io_out_bits),
        .io_out_overflow (io_out_overflow),
        .io_out_invalid  (io_out_invalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operand, wait for the result, check it, then consume it.
    task automatic run(input string tag, input logic [63:0] op,
                       input logic [63:0] exp, input logic eovf,
                       input logic einv, input int elat);
        int lat;
        @(negedge clock);
        chk({tag, ".in_ready"}, 64'(io_in_ready), 64'd1);
        io_in_valid  = 1'b1;
        io_in_bits   = op;
        io_out_ready = 1'b0;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        lat = 1;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!io_out_valid && lat < 40);
        chk({tag, ".latency"}, 64'(lat), 64'(elat));
        chk({tag, ".bits"}, io_out_bits, exp);
        chk({tag, ".overflow"}, 64'(io_out_overflow), 64'(eovf));
        chk({tag, ".invalid"}, 64'(io_out_invalid), 64'(einv));
        chk({tag, ".busy"}, 64'(io_in_ready), 64'd0);
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        chk({tag, ".consumed"}, 64'(io_out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_bits   = 64'd0;
        io_out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst.in_ready", 64'(io_in_ready), 64'd1);
        chk("rst.out_valid", 64'(io_out_valid), 64'd0);
        chk("rst.bits", io_out_bits, 64'd0);
        chk("rst.overflow", 64'(io_out_overflow), 64'd0);
        chk("rst.invalid", 64'(io_out_invalid), 64'd0);

        run("p100", 64'h4059_0000_0000_0000, 64'h0000_0000_0000_0064, 0, 0, 8);
        run("m3p5", 64'hC00C_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 9);
        run("half", 64'h3FE0_0000_0000_0000, 64'd0, 0, 0, 2);
        run("m1", 64'hBFF0_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 9);
        run("two52", 64'h4330_0000_0000_0000, 64'h0010_0000_0000_0000, 0, 0, 2);
        run("two62", 64'h43D0_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 0, 4);
        run("subn", 64'h8000_0000_0000_0001, 64'd0, 0, 0, 2);
        run("two63", 64'h43E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 2);
        run("mtwo63", 64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 2);
        run("minf", 64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0, 2);
        run("pinf", 64'h7FF0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 2);
        run("nan", 64'h7FF8_0000_0000_0000, 64'd0, 0, 1, 2);

        // Left shift with output backpressure; new operands must be ignored
        @(negedge clock);
        io_in_valid = 1'b1;
        io_in_bits  = 64'h43C0_0000_0000_0001;
        @(posedge clock);
        #1;
        io_in_bits = 64'h4059_0000_0000_0000;
        lat = 1;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!io_out_valid && lat < 40);
        chk("hold.latency", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", 64'(io_out_valid), 64'd1);
            chk("hold.bits", io_out_bits, 64'h2000_0000_0000_0200);
            chk("hold.flags", {62'd0, io_out_overflow, io_out_invalid}, 64'd0);
            chk("hold.in_ready", 64'(io_in_ready), 64'd0);
            @(posedge clock);
            #1;
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        chk("hold.consumed", 64'(io_out_valid), 64'd0);
        chk("hold.idle", 64'(io_in_ready), 64'd1);

        // Reset on the third SHIFT cycle of 100.0
        @(negedge clock);
        io_in_valid = 1'b1;
        io_in_bits  = 64'h4059_0000_0000_0000;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("rmid.busy", 64'(io_in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rmid.in_ready", 64'(io_in_ready), 64'd1);
        chk("rmid.out_valid", 64'(io_out_valid), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("rmid.no_result", 64'(io_out_valid), 64'd0);
        end

        run("after", 64'hC00C_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
